// File: rtl/ysyx_23060077_bpu_btb_pkg.sv
// ysyx_23060077_bpu_btb_pkg: shared widths, counter-init helpers and update kinds for the BTB predictor
package ysyx_23060077_bpu_btb_pkg;
    localparam int YSYX_23060077_DATA_WIDTH = 32;
    localparam int YSYX_23060077_BTB_DEPTH  = 16;
    localparam int YSYX_23060077_CNT_WIDTH  = 2;

    typedef enum logic [1:0] {
        UPD_NONE,
        UPD_HIT,
        UPD_ALLOC,
        UPD_KILL
    } upd_e;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int tag_width(input int dw, input int depth);
        return dw - $clog2(depth) - 2;
    endfunction

    // Weakly not-taken sits just below the MSB threshold, weakly taken just on it.
    function automatic int cnt_weak_nt(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int cnt_weak_t(input int w);
        return 1 << (w - 1);
    endfunction
endpackage

// File: rtl/ysyx_23060077_sat_cnt.sv
// ysyx_23060077_sat_cnt: next-state function of a saturating up/down direction counter
module ysyx_23060077_sat_cnt #(
    parameter int CNT_WIDTH = 2
) (
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] nxt
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    assign nxt = inc ? ((cnt == CNT_MAX) ? cnt : cnt + 1'b1)
                     : ((cnt == '0) ? cnt : cnt - 1'b1);
endmodule

// File: rtl/ysyx_23060077_bpu_btb.sv
// ysyx_23060077_bpu_btb: direct-mapped BTB next-PC predictor with mispredict and trap/return redirect
module ysyx_23060077_bpu_btb
    import ysyx_23060077_bpu_btb_pkg::*;
#(
    parameter int DATA_WIDTH = YSYX_23060077_DATA_WIDTH,
    parameter int BTB_DEPTH  = YSYX_23060077_BTB_DEPTH,
    parameter int CNT_WIDTH  = YSYX_23060077_CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_valid,
    input  logic [DATA_WIDTH-1:0] fetch_pc,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_pc,
    input  logic                  exu_valid,
    input  logic                  exu_is_branch,
    input  logic                  exu_is_jump,
    input  logic [DATA_WIDTH-1:0] exu_pc,
    input  logic                  exu_taken,
    input  logic [DATA_WIDTH-1:0] exu_target,
    input  logic                  exu_pred_taken,
    input  logic [DATA_WIDTH-1:0] exu_pred_pc,
    input  logic                  exu_csr_ecall,
    input  logic                  exu_csr_mret,
    input  logic [DATA_WIDTH-1:0] csr_mtvec,
    input  logic [DATA_WIDTH-1:0] csr_mepc,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [31:0]           mispredict_cnt
);
    localparam int IDX_W = idx_width(BTB_DEPTH);
    localparam int TAG_W = tag_width(DATA_WIDTH, BTB_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT   = CNT_WIDTH'(cnt_weak_nt(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK_T = CNT_WIDTH'(cnt_weak_t(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    logic                  valid_q [BTB_DEPTH];
    logic [TAG_W-1:0]      tag_q   [BTB_DEPTH];
    logic [DATA_WIDTH-1:0] tgt_q   [BTB_DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_q   [BTB_DEPTH];

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic             ctl, mispredict, ecall_v, mret_v;
    logic [DATA_WIDTH-1:0] fetch_seq, exu_seq;
    logic [CNT_WIDTH-1:0]  cnt_step, hit_cnt, alloc_cnt;
    upd_e             upd;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[DATA_WIDTH-1:IDX_W+2];
    assign e_idx = exu_pc[IDX_W+1:2];
    assign e_tag = exu_pc[DATA_WIDTH-1:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    assign fetch_seq = fetch_pc + DATA_WIDTH'(4);
    assign exu_seq   = exu_pc + DATA_WIDTH'(4);

    // Lookup reads pre-update table contents; no bypass from the EXU write.
    assign pred_taken = ~reset & fetch_valid & f_hit & cnt_q[f_idx][CNT_WIDTH-1];
    assign pred_pc    = pred_taken ? tgt_q[f_idx] : fetch_seq;

    assign ctl     = exu_valid & (exu_is_branch | exu_is_jump);
    assign ecall_v = exu_valid & exu_csr_ecall;
    assign mret_v  = exu_valid & exu_csr_mret;

    // A predicted-taken non-control instruction means a tag alias produced a false hit.
    assign mispredict = (ctl & (exu_taken != exu_pred_taken))
                      | (ctl & exu_taken & (exu_target != exu_pred_pc))
                      | (exu_valid & ~ctl & exu_pred_taken);

    assign redirect_valid = ~reset & (mret_v | ecall_v | mispredict);
    assign redirect_pc    = mret_v ? csr_mepc
                          : ecall_v ? csr_mtvec
                          : (ctl & exu_taken) ? exu_target
                          : exu_seq;

    ysyx_23060077_sat_cnt #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_sat_cnt (
        .cnt(cnt_q[e_idx]),
        .inc(exu_taken),
        .nxt(cnt_step)
    );

    assign hit_cnt   = exu_is_jump ? CNT_MAX : cnt_step;
    assign alloc_cnt = exu_is_jump ? CNT_MAX : CNT_WEAK_T;

    // Traps retire without training the table.
    assign upd = (~exu_valid | ecall_v | mret_v) ? UPD_NONE
               : ctl ? (e_hit ? UPD_HIT : (exu_taken ? UPD_ALLOC : UPD_NONE))
               : (e_hit ? UPD_KILL : UPD_NONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= CNT_INIT;
            end
            mispredict_cnt <= '0;
        end else begin
            if (mispredict && mispredict_cnt != '1)
                mispredict_cnt <= mispredict_cnt + 32'd1;
            case (upd)
                UPD_HIT: begin
                    cnt_q[e_idx] <= hit_cnt;
                    if (exu_taken)
                        tgt_q[e_idx] <= exu_target;
                end
                UPD_ALLOC: begin
                    valid_q[e_idx] <= 1'b1;
                    tag_q[e_idx]   <= e_tag;
                    tgt_q[e_idx]   <= exu_target;
                    cnt_q[e_idx]   <= alloc_cnt;
                end
                UPD_KILL: valid_q[e_idx] <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060077_bpu_btb.sv
// tb_ysyx_23060077_bpu_btb: directed scoreboard bench for the BTB next-PC predictor
module tb_ysyx_23060077_bpu_btb;
    localparam int P_TK = 0, P_PC = 1, R_V = 2, R_PC = 3, M_CNT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid, pred_taken, exu_valid, exu_is_branch, exu_is_jump;
    logic        exu_taken, exu_pred_taken, exu_csr_ecall, exu_csr_mret, redirect_valid;
    logic [31:0] fetch_pc, pred_pc, exu_pc, exu_target, exu_pred_pc;
    logic [31:0] csr_mtvec, csr_mepc, redirect_pc, mispredict_cnt;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    ysyx_23060077_bpu_btb dut (
        .clock(clock), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_pc(pred_pc),
        .exu_valid(exu_valid), .exu_is_branch(exu_is_branch), .exu_is_jump(exu_is_jump),
        .exu_pc(exu_pc), .exu_taken(exu_taken), .exu_target(exu_target),
        .exu_pred_taken(exu_pred_taken), .exu_pred_pc(exu_pred_pc),
        .exu_csr_ecall(exu_csr_ecall), .exu_csr_mret(exu_csr_mret),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            P_TK:    return {31'd0, pred_taken};
            P_PC:    return pred_pc;
            R_V:     return {31'd0, redirect_valid};
            R_PC:    return redirect_pc;
            default: return mispredict_cnt;
        endcase
    endfunction

    task automatic expect_out(input int sel, input logic [31:0] v, input string n);
        exp_t e;
        e.sel  = sel;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    // Monitor: drains every expectation queued for this cycle at the falling edge.
    initial forever begin
        @(negedge clock);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = sb.pop_front();
            got = observe(e.sel);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, got, e.val);
            end
        end
    end

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        exu_valid = 0; exu_is_branch = 0; exu_is_jump = 0; exu_pc = 0;
        exu_taken = 0; exu_target = 0; exu_pred_taken = 0; exu_pred_pc = 0;
        exu_csr_ecall = 0; exu_csr_mret = 0;
    endtask

    task automatic exu(input logic br, input logic jp, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ppc);
        exu_valid = 1; exu_is_branch = br; exu_is_jump = jp; exu_pc = pc;
        exu_taken = tk; exu_target = tgt; exu_pred_taken = ptk; exu_pred_pc = ppc;
        exu_csr_ecall = 0; exu_csr_mret = 0;
    endtask

    initial begin
        int n;
        idle();
        csr_mtvec = 32'h8000_1000; csr_mepc = 32'h0;
        fetch_valid = 1; fetch_pc = 32'h8000_0000;
        #1;
        exu_valid = 1; exu_csr_ecall = 1;
        expect_out(P_TK, 0, "rst_pred_taken");
        expect_out(P_PC, 32'h8000_0004, "rst_pred_pc");
        expect_out(R_V, 0, "rst_redirect_forced_off");
        expect_out(M_CNT, 0, "rst_mispredict_cnt");
        next_cyc(); reset = 0; idle();
        expect_out(P_PC, 32'h8000_0004, "post_rst_pred_pc");
        expect_out(R_V, 0, "post_rst_no_redirect");
        next_cyc(); exu(1, 0, 32'h8000_0010, 1, 32'h8000_0100, 0, 32'h8000_0014);
        expect_out(R_V, 1, "br_taken_miss_redirect");
        expect_out(R_PC, 32'h8000_0100, "br_taken_miss_pc");
        expect_out(M_CNT, 0, "cnt_before_edge");
        next_cyc(); idle(); fetch_pc = 32'h8000_0010;
        expect_out(P_TK, 1, "alloc_pred_taken");
        expect_out(P_PC, 32'h8000_0100, "alloc_pred_pc");
        expect_out(M_CNT, 1, "cnt_after_first");
        expect_out(R_V, 0, "idle_no_redirect");
        next_cyc(); exu(1, 0, 32'h8000_0010, 0, 32'h8000_0100, 1, 32'h8000_0100);
        expect_out(R_V, 1, "br_nt_redirect");
        expect_out(R_PC, 32'h8000_0014, "br_nt_pc");
        expect_out(P_TK, 1, "no_bypass_pred");
        next_cyc(); exu(1, 0, 32'h8000_0010, 0, 32'h8000_0100, 0, 32'h8000_0014);
        expect_out(P_TK, 0, "weak_nt_pred");
        expect_out(P_PC, 32'h8000_0014, "weak_nt_pred_pc");
        expect_out(R_V, 0, "correct_nt_no_redirect");
        next_cyc();
        expect_out(R_V, 0, "sat_low_no_redirect");
        expect_out(P_TK, 0, "sat_low_pred");
        expect_out(M_CNT, 2, "cnt_after_nt");
        next_cyc(); exu(0, 1, 32'h8000_0010, 1, 32'h8000_0100, 0, 32'h8000_0014);
        expect_out(R_V, 1, "jump_hit_redirect");
        expect_out(R_PC, 32'h8000_0100, "jump_hit_pc");
        next_cyc(); exu(0, 0, 32'h8000_0010, 1, 32'h8000_0999, 1, 32'h8000_0100);
        expect_out(P_TK, 1, "jump_max_pred");
        expect_out(P_PC, 32'h8000_0100, "jump_max_pred_pc");
        expect_out(R_V, 1, "alias_redirect");
        expect_out(R_PC, 32'h8000_0014, "alias_pc");
        expect_out(M_CNT, 3, "cnt_before_alias");
        next_cyc(); idle();
        expect_out(P_TK, 0, "alias_invalidated");
        expect_out(P_PC, 32'h8000_0014, "alias_inv_pred_pc");
        expect_out(M_CNT, 4, "cnt_after_alias");
        next_cyc(); exu(1, 0, 32'h8000_0040, 1, 32'h8000_0500, 0, 32'h8000_0044); exu_csr_ecall = 1;
        expect_out(R_V, 1, "ecall_redirect");
        expect_out(R_PC, 32'h8000_1000, "ecall_over_mispredict");
        next_cyc(); exu(0, 0, 32'h8000_0050, 0, 0, 0, 32'h8000_0054);
        exu_csr_ecall = 1; exu_csr_mret = 1; csr_mepc = 32'h8000_0abc; fetch_pc = 32'h8000_0040;
        expect_out(R_V, 1, "mret_redirect");
        expect_out(R_PC, 32'h8000_0abc, "mret_over_ecall");
        expect_out(P_TK, 0, "ecall_no_alloc");
        expect_out(M_CNT, 5, "cnt_after_ecall_cycle");
        next_cyc(); exu(0, 1, 32'h8000_0020, 1, 32'h8000_0200, 0, 32'h8000_0024); fetch_pc = 32'h8000_0020;
        expect_out(R_V, 1, "jalr_first_redirect");
        expect_out(R_PC, 32'h8000_0200, "jalr_first_pc");
        expect_out(P_TK, 0, "jalr_pre_alloc_pred");
        next_cyc(); exu(0, 1, 32'h8000_0020, 1, 32'h8000_0300, 1, 32'h8000_0200);
        expect_out(P_TK, 1, "jalr_pred_taken");
        expect_out(P_PC, 32'h8000_0200, "jalr_old_target");
        expect_out(R_V, 1, "jalr_target_redirect");
        expect_out(R_PC, 32'h8000_0300, "jalr_target_pc");
        expect_out(M_CNT, 6, "cnt_before_jalr2");
        next_cyc(); idle();
        expect_out(P_PC, 32'h8000_0300, "jalr_target_rewritten");
        expect_out(M_CNT, 7, "cnt_after_jalr2");
        next_cyc(); fetch_pc = 32'h8000_0060;
        expect_out(P_TK, 0, "tag_mismatch_pred");
        expect_out(P_PC, 32'h8000_0064, "tag_mismatch_pc");
        next_cyc(); fetch_valid = 0; fetch_pc = 32'h8000_0020;
        expect_out(P_TK, 0, "no_fetch_valid_pred");
        expect_out(P_PC, 32'h8000_0024, "no_fetch_valid_pc");
        next_cyc(); fetch_valid = 1; reset = 1; exu(0, 0, 32'h8000_0020, 0, 0, 1, 0);
        expect_out(P_TK, 0, "midrun_rst_pred");
        expect_out(P_PC, 32'h8000_0024, "midrun_rst_pc");
        expect_out(M_CNT, 0, "midrun_rst_cnt");
        expect_out(R_V, 0, "midrun_rst_redirect");
        next_cyc(); reset = 0; idle();
        expect_out(P_TK, 0, "after_rst_still_miss");
        next_cyc(); fetch_pc = 32'hffff_fffc;
        expect_out(P_PC, 32'h0000_0000, "pc_wrap");
        expect_out(P_TK, 0, "pc_wrap_pred");
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
